// File: rtl/lut_build_ctrl_pkg.sv
// ============================================================================
// lut_build_ctrl_pkg : shared constants and state type for the LUT builder
// Revision 1.0
// ============================================================================
`default_nettype none

package lut_build_ctrl_pkg;

    localparam logic [2:0]  ALG_SPN8   = 3'b000;
    localparam logic [12:0] LAST_SPN8  = 13'd15;
    localparam logic [12:0] LAST_SPN16 = 13'd8191;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ABORT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lut_pattern_fmt.sv
// ============================================================================
// lut_pattern_fmt : table index + algorithm mode -> 128-bit plaintext pattern
// Revision 1.0
// ============================================================================
`default_nettype none

module lut_pattern_fmt
    import lut_build_ctrl_pkg::*;
(
    input  logic [12:0]  idx,
    input  logic [2:0]   mode,
    output logic [127:0] pattern
);

    logic [127:0] pat8;
    logic [127:0] pat16;

    // (16*i + k) mod 256 is simply {i[3:0], k}; likewise {i, k[2:0]} for halfwords
    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign pat8[127-8*k -: 8] = {idx[3:0], 4'(k)};
    end

    for (genvar k = 0; k < 8; k++) begin : g_half
        assign pat16[127-16*k -: 16] = {idx, 3'(k)};
    end

    assign pattern = (mode == ALG_SPN8) ? pat8 : pat16;

endmodule

`default_nettype wire

// File: rtl/lut_build_ctrl.sv
// ============================================================================
// lut_build_ctrl : sweeps LUT indices, issues patterns to the cipher engine
//                  and writes the in-order results into LUT memory
// Revision 1.0
// ============================================================================
`default_nettype none

module lut_build_ctrl
    import lut_build_ctrl_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        alg_mode,
    output logic              enc_in_valid,
    input  logic              enc_in_ready,
    output logic [127:0]      enc_in_data,
    input  logic              enc_out_valid,
    input  logic [127:0]      enc_out_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [127:0]      mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    // one extra bit so the index counters can rest at last+1
    localparam int         CNT_W     = ADDR_W + 1;
    localparam logic [3:0] MAX_OUT_V = 4'(MAX_OUT);

    state_t           state;
    state_t           state_nx;
    logic [2:0]       mode;
    logic [CNT_W-1:0] iss_idx;
    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W-1:0] end_idx;
    logic [3:0]       outstanding;
    logic [127:0]     pattern;
    logic             start_acc;
    logic             issue;
    logic             retire;
    logic             spurious;
    logic             wr_now;
    logic             last_issue;

    assign last_idx   = (mode == ALG_SPN8) ? CNT_W'(LAST_SPN8) : CNT_W'(LAST_SPN16);
    assign end_idx    = last_idx + CNT_W'(1);
    assign start_acc  = (state == IDLE) && start;
    assign issue      = enc_in_valid && enc_in_ready;
    assign retire     = enc_out_valid && (outstanding != 4'd0);
    assign spurious   = enc_out_valid && (outstanding == 4'd0);
    assign wr_now     = retire && ((state == ISSUE) || (state == DRAIN));
    assign last_issue = issue && (iss_idx == last_idx);

    lut_pattern_fmt u_fmt (
        .idx     (13'(iss_idx)),
        .mode    (mode),
        .pattern (pattern)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: begin
                if (abort)           state_nx = ABORT;
                else if (last_issue) state_nx = DRAIN;
            end
            DRAIN: begin
                if (abort) state_nx = ABORT;
                else if ((outstanding == 4'd0) && (wr_idx == end_idx)) state_nx = IDLE;
            end
            ABORT: if (outstanding == 4'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // data is forced to zero when not offered so idle/reset outputs read as 0
    always_comb begin
        enc_in_valid = (state == ISSUE) && (outstanding < MAX_OUT_V);
        busy         = (state != IDLE);
        enc_in_data  = enc_in_valid ? pattern : 128'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode        <= 3'd0;
            iss_idx     <= '0;
            wr_idx      <= '0;
            outstanding <= 4'd0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 128'd0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_we  <= wr_now;
            done    <= (state == DRAIN) && (state_nx == IDLE);
            aborted <= (state == ABORT) && (state_nx == IDLE);

            if (spurious)       err <= 1'b1;
            else if (start_acc) err <= 1'b0;

            if (start_acc) begin
                mode        <= alg_mode;
                iss_idx     <= '0;
                wr_idx      <= '0;
                outstanding <= 4'd0;
            end else begin
                if (issue) iss_idx <= iss_idx + CNT_W'(1);

                if (issue && !retire)      outstanding <= outstanding + 4'd1;
                else if (!issue && retire) outstanding <= outstanding - 4'd1;

                if (wr_now) begin
                    wr_idx    <= wr_idx + CNT_W'(1);
                    mem_addr  <= wr_idx[ADDR_W-1:0];
                    mem_wdata <= enc_out_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/lut_build_ctrl.md
# lut_build_ctrl

Sequencer for white-box lookup-table construction. It sweeps the table index for the selected algorithm mode and builds the 128-bit plaintext pattern for each index. Patterns are issued to the cipher engine over a valid/ready handshake, and results return in order. Each returned ciphertext is written to LUT memory at its index. The block sits between the top-level configuration FSM, the cipher engine and the LUT RAM write port.

## Interface
- `MAX_OUT`, default 4: maximum engine transactions in flight (1..15).
- `ADDR_W`, default 13: LUT address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: build request; accepted only in IDLE.
- `abort` in 1: cancel build; honoured in ISSUE or DRAIN.
- `alg_mode` in 3: sampled on accepted `start`. 3'b000 = 8-bit SPN with 16 entries; any other value = 16-bit SPN with 8192 entries.
- `enc_in_valid` out 1: plaintext offered to the engine.
- `enc_in_ready` in 1: engine accepts the plaintext.
- `enc_in_data` out 128: plaintext pattern.
- `enc_out_valid` in 1: engine result; no backpressure.
- `enc_out_data` in 128: ciphertext.
- `mem_we` out 1: LUT write strobe.
- `mem_addr` out ADDR_W: LUT write address.
- `mem_wdata` out 128: LUT write data.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a build completes.
- `aborted` out 1: one-cycle pulse when an aborted build finishes draining.
- `err` out 1: sticky flag for a result received while nothing is outstanding. Cleared by reset or by an accepted `start`.

## Operation
- States and transitions:
  - IDLE → ISSUE on `start`.
  - ISSUE → DRAIN after the last index has been issued.
  - DRAIN → IDLE when `outstanding`==0 and the last write is done; `done` pulses.
  - ISSUE or DRAIN → ABORT on `abort`.
  - ABORT → IDLE when `outstanding`==0; `aborted` pulses.
- `last` = 15 for mode 000, otherwise 8191.
- Counters, all cleared on start:
  - `iss_idx`: next index to issue.
  - `wr_idx`: next address to write.
  - `outstanding`: 0..MAX_OUT.
- Pattern for index i, MSB first:
  - Mode 000: byte k (k=0..15) = (16·i + k) mod 256.
  - Other modes: halfword k (k=0..7) = (8·i + k) mod 65536.
- `enc_in_valid` = state is ISSUE and `outstanding` < MAX_OUT. `enc_in_data` is held stable while valid && !ready.
- An issue occurs on valid && ready; `iss_idx` increments.
- A retire occurs on `enc_out_valid` with `outstanding` > 0.
- Issue and retire in the same cycle leave `outstanding` unchanged.
- Retire in ISSUE or DRAIN: on the next cycle `mem_we`=1, `mem_addr`=`wr_idx`, `mem_wdata`=ciphertext; then `wr_idx` increments.
- Retire in ABORT: `outstanding` decrements and no write is performed.
- `enc_out_valid` with `outstanding`==0: sets `err`; the data is ignored and no write occurs.
- `start` while `busy`: ignored; `alg_mode` is not resampled.
- `abort` in IDLE: ignored. `abort` together with `start` in IDLE: `start` wins.
- Issue on the last index wraps nothing; `iss_idx` stops at `last`+1.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset asserted mid-build: returns to IDLE on the next edge. In-flight engine results arriving after reset raise `err`.
- `start` at cycle 0 → `busy` and `enc_in_valid` high at cycle 1, with the pattern for index 0.
- Engine result at cycle n → `mem_we` at cycle n+1 (one-cycle latency).
- `done`: asserted the cycle after the final `mem_we`; `busy` falls in the same cycle.
- Minimum build time with an always-ready, one-cycle engine: `last` + 4 cycles.
- `abort` at cycle n → `enc_in_valid` low at cycle n+1.

## Structure
- Shared package:
  - `ALG_SPN8` = 3'b000.
  - `LAST_SPN8` = 13'd15.
  - `LAST_SPN16` = 13'd8191.
  - State enum: IDLE, ISSUE, DRAIN, ABORT.
- Sub-module `lut_pattern_fmt`: combinational index + mode → 128-bit pattern. This is the only sub-module; counters and the FSM live in the top.

## Test plan
- Mode 000, always-ready engine with 1-cycle latency: 16 writes at addresses 0..15. Address 1 data = 0x101112…1F, address 15 = 0xF0F1…FF. `done` asserted at cycle 19.
- Mode 001, final entry: write to address 8191 with pattern 0xFFF8FFF9…FFFF; exactly 8192 `mem_we` pulses.
- Engine latency 10 with MAX_OUT=4: `enc_in_valid` drops when `outstanding` reaches 4. `outstanding` never exceeds 4, and writes stay in order.
- `enc_in_ready` low for 5 cycles mid-issue: `enc_in_data` stable throughout, no index skipped or duplicated.
- `abort` with 3 outstanding: no further issues, 3 results discarded with no `mem_we`, `aborted` pulses, `done` stays low.
- Spurious `enc_out_valid` in IDLE: `err`=1 and held until the next `start`. `start` while busy: no effect.
